logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between NREQ requesters. Each requester presents an opcode and two operands. The block grants one requester at a time, executes the op, and returns the result tagged with the requester ID. It sits between several control clients and the common gate datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits
IDW, $clog2(NREQ), width of requester ID (derived, localparam)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request level; bit i = requester i
op_flat  input  3*NREQ  opcode of requester i at bits [3i+2:3i]
a_flat  input  W*NREQ  operand A of requester i at bits [W*i+W-1:W*i]
b_flat  input  W*NREQ  operand B of requester i, same packing
gnt  output  NREQ  one-hot grant, one-cycle pulse
res_valid  output  1  result strobe, one-cycle pulse
res_id  output  IDW  requester ID owning res_data
res_data  output  W  operation result
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n). Assertion immediately forces state=IDLE, gnt=0, res_valid=0, res_id=0, res_data=0, busy=0, rr pointer=0, operand registers=0.
- Opcodes (3-bit): 0 AND, 1 OR, 2 NOT (~a; b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved (result all zeros).
- FSM states: IDLE, EXEC, RESP. Each transition occurs on a rising clk edge.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the winner: the first set req bit searching upward from ptr, modulo NREQ.
  - Latch the winner's op/a/b and ID, set gnt[winner]=1, go to EXEC.
- EXEC:
  - gnt<=0.
  - res_data<=f(op,a,b); res_id<=latched ID; res_valid<=1.
  - Go to RESP.
- RESP:
  - res_valid<=0; ptr<=(ID+1) mod NREQ; go to IDLE.
  - res_data/res_id hold their values until the next EXEC.
- Timing: gnt is high in cycle T+1 after arbitrating edge T. res_valid is high in cycle T+2. Throughput is one op per 3 cycles. busy is high in EXEC and RESP.
- req is sampled only in IDLE. Operands are captured at the grant edge, so a requester may change a/b/op after gnt. A requester holding req after its gnt is treated as a new request at the next IDLE.
- Fairness: after servicing ID k, ID k has lowest priority. With all requests continuously asserted, grant order is 0,1,...,NREQ-1,0,...
- Wrap-around: ptr=NREQ-1 servicing NREQ-1 sets ptr=0. A search from ptr wraps past NREQ-1 to 0.
- Simultaneous events: req bits changing in EXEC/RESP have no effect until IDLE. The EXEC→RESP and RESP→IDLE transitions are unconditional.
- Reset mid-operation: the pending transaction is discarded, with no res_valid and no further gnt. Arbitration restarts from ptr=0 after release.

Optional Feature:
Macro LOGIC_ARB_ERR_EN.
- Defined: adds output res_err (1 bit), reset to 0. res_err is registered alongside res_data in EXEC: 1 when the latched op==7, else 0. It stays valid with res_valid and holds like res_data.
- Undefined: no res_err port. Op 7 silently returns all zeros. All other behaviour is identical.

Test Plan:
- Single request: req=0001, op0=0 (AND), a0=8'hF0, b0=8'hCC → gnt=0001 one cycle after the arbitrating edge; next cycle res_valid=1, res_id=0, res_data=8'hC0; busy high for 2 cycles.
- Op sweep on requester 2, a=F0, b=CC: OR→FC, NOT→0F, NAND→3F, NOR→03, XOR→3C, XNOR→C3, op7→00. With LOGIC_ARB_ERR_EN, res_err=1 only for op7.
- Round robin with req=1111 held: gnt sequence 0001,0010,0100,1000,0001, each 3 cycles apart; res_id follows 0,1,2,3,0.
- Priority rotation and wrap: service ID 3, then req=1001 → ID 0 granted. Service ID 0, then req=1001 → ID 3 granted.
- Operand capture: change a/b/op of the granted requester in the gnt cycle → res_data reflects the values present at the grant edge.
- Reset mid-op: assert rst_n=0 while in EXEC → gnt/res_valid/busy/res_data go 0 immediately, with no res_valid pulse. After release with req=0010 → ID 1 granted (ptr=0 search).

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit between NREQ requesters.
// Optional LOGIC_ARB_ERR_EN adds a res_err flag that marks the reserved opcode 7.
module logic_unit_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] op_flat,
  input  logic [W*NREQ-1:0] a_flat,
  input  logic [W*NREQ-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data,
  output logic              busy
`ifdef LOGIC_ARB_ERR_EN
  ,
  output logic              res_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [W-1:0]    res_data_q, res_data_d;

  logic [2:0]      op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];

  logic [IDW:0]    search_idx;
  logic [IDW-1:0]  win_id;
  logic            win_found;
  logic [W-1:0]    alu_res;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = op_flat[3*i +: 3];
      a_arr[i]  = a_flat[W*i +: W];
      b_arr[i]  = b_flat[W*i +: W];
    end
  end

  // First set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    search_idx = '0;
    win_id     = '0;
    win_found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      search_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (search_idx >= (IDW+1)'(NREQ)) begin
        search_idx = search_idx - (IDW+1)'(NREQ);
      end
      if (!win_found && req[search_idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = search_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    case (op_q)
      3'd0:    alu_res = a_q & b_q;
      3'd1:    alu_res = a_q | b_q;
      3'd2:    alu_res = ~a_q;
      3'd3:    alu_res = ~(a_q & b_q);
      3'd4:    alu_res = ~(a_q | b_q);
      3'd5:    alu_res = a_q ^ b_q;
      3'd6:    alu_res = ~(a_q ^ b_q);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          op_d    = op_arr[win_id];
          a_d     = a_arr[win_id];
          b_d     = b_arr[win_id];
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_res;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // The serviced requester drops to lowest priority.
        if (id_q == IDW'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = id_q + IDW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef LOGIC_ARB_ERR_EN
  logic res_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_err_q <= (op_q == 3'd7);
    end
  end

  assign res_err = res_err_q;
`endif

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: timestamp-based transaction model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] op_flat = '0;
  logic [31:0] a_flat = '0;
  logic [31:0] b_flat = '0;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        busy;
`ifdef LOGIC_ARB_ERR_EN
  logic        res_err;
`endif

  logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_flat   (op_flat),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
`ifdef LOGIC_ARB_ERR_EN
    ,
    .res_err   (res_err)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // Model: a grant at edge g yields a result at edge g+1 and frees the unit at edge g+2.
  int         m_ptr = 0;
  int         edge_n = 0;
  int         g_edge = -1;
  int         m_id = 0;
  logic [2:0] m_op = '0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic [3:0] e_gnt = '0;
  logic       e_rv = 1'b0;
  logic       e_busy = 1'b0;
  logic [1:0] e_id = '0;
  logic [7:0] e_data = '0;
  logic       e_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ptr = 0; g_edge = -1; edge_n = 0;
      e_gnt = '0; e_rv = 1'b0; e_busy = 1'b0; e_id = '0; e_data = '0; e_err = 1'b0;
    end else begin
      edge_n++;
      if (g_edge >= 0 && edge_n == g_edge + 1) begin
        e_gnt  = '0;
        e_rv   = 1'b1;
        e_id   = 2'(m_id);
        e_data = f(m_op, m_a, m_b);
        e_err  = (m_op == 3'd7);
      end else if (g_edge >= 0 && edge_n == g_edge + 2) begin
        e_rv   = 1'b0;
        e_busy = 1'b0;
        m_ptr  = (m_id + 1) % NREQ;
        g_edge = -1;
      end else if (req != 0) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req[(m_ptr + k) % NREQ]) m_id = (m_ptr + k) % NREQ;
        end
        m_op   = op_flat[3*m_id +: 3];
        m_a    = a_flat[8*m_id +: 8];
        m_b    = b_flat[8*m_id +: 8];
        e_gnt  = 4'b0001 << m_id;
        e_busy = 1'b1;
        g_edge = edge_n;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_gnt", gnt, e_gnt);
      chk("model_res_valid", res_valid, e_rv);
      chk("model_busy", busy, e_busy);
      chk("model_res_id", res_id, e_id);
      chk("model_res_data", res_data, e_data);
`ifdef LOGIC_ARB_ERR_EN
      chk("model_res_err", res_err, e_err);
`endif
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    op_flat[3*i +: 3] = op;
    a_flat[8*i +: 8]  = a;
    b_flat[8*i +: 8]  = b;
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int n);
    g = '0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n++;
      if (gnt != 0) begin
        g = gnt;
        break;
      end
    end
    if (g == 0) begin
      total++;
      $display("FAIL gnt_timeout: no grant within 12 cycles at %0t", $time);
    end
  endtask

  logic [7:0] exp_tab [8];
  logic [3:0] rr_seq [5];
  logic [3:0] g;
  int         n;

  initial begin
    exp_tab = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h00};
    rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_res_id", res_id, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single request.
    set_req(0, 3'd0, 8'hF0, 8'hCC);
    req = 4'b0001;
    wait_gnt(g, n);
    req = '0;
    chk("single_gnt", g, 4'b0001);
    chk("single_latency", n, 1);
    chk("single_busy0", busy, 1);
    @(negedge clk);
    chk("single_res_valid", res_valid, 1);
    chk("single_res_id", res_id, 0);
    chk("single_res_data", res_data, 8'hC0);
    chk("single_busy1", busy, 1);
    @(negedge clk);
    chk("single_busy_end", busy, 0);
    chk("single_rv_end", res_valid, 0);

    // Opcode sweep on requester 2.
    for (int op = 1; op < 8; op++) begin
      set_req(2, 3'(op), 8'hF0, 8'hCC);
      req = 4'b0100;
      wait_gnt(g, n);
      req = '0;
      chk("sweep_gnt", g, 4'b0100);
      @(negedge clk);
      chk($sformatf("sweep_op%0d_data", op), res_data, exp_tab[op]);
`ifdef LOGIC_ARB_ERR_EN
      chk($sformatf("sweep_op%0d_err", op), res_err, (op == 7) ? 1 : 0);
`endif
    end

    // Round robin from a fresh pointer.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 3), 8'(8'h11 * (i + 1)), 8'h5A);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(g, n);
      chk($sformatf("rr_gnt%0d", j), g, rr_seq[j]);
      if (j > 0) chk($sformatf("rr_spacing%0d", j), n, 3);
    end

    // Wrap: after ID 0 the search starts at 1 and finds 3; after 3 it wraps to 0.
    req = 4'b1001;
    wait_gnt(g, n);
    chk("wrap_after0", g, 4'b1000);
    wait_gnt(g, n);
    chk("wrap_after3", g, 4'b0001);
    req = '0;

    // Operand capture at the grant edge.
    set_req(1, 3'd0, 8'hF0, 8'hCC);
    req = 4'b0010;
    wait_gnt(g, n);
    chk("capture_gnt", g, 4'b0010);
    set_req(1, 3'd1, 8'h00, 8'h00);
    req = '0;
    @(negedge clk);
    chk("capture_data", res_data, 8'hC0);

    // Reset while in EXEC.
    set_req(1, 3'd5, 8'hAA, 8'h0F);
    req = 4'b0010;
    wait_gnt(g, n);
    chk("midrst_gnt", g, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt_low", gnt, 0);
    chk("midrst_busy_low", busy, 0);
    chk("midrst_rv_low", res_valid, 0);
    chk("midrst_data_low", res_data, 0);
    @(negedge clk);
    chk("midrst_no_rv", res_valid, 0);
    set_req(3, 3'd0, 8'hFF, 8'hFF);
    req   = 4'b1010;
    rst_n = 1'b1;
    wait_gnt(g, n);
    chk("postrst_gnt", g, 4'b0010);
    chk("postrst_latency", n, 1);
    req = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
